// File: rtl/sc_robert_stream_io.sv
// Stochastic-computing stream I/O: turns a 2x2 pixel quad into LFSR-compared bit streams and counts returned sc_out ones.
// Optional SC_SHARED_RNG_EN: all four pixel streams compare against one shared LFSR instead of four private ones.
module sc_robert_stream_io #(
    parameter int WIDTH    = 8,
    parameter int PIPE_DLY = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p00,
    input  logic [WIDTH-1:0] p01,
    input  logic [WIDTH-1:0] p10,
    input  logic [WIDTH-1:0] p11,
    output logic             r00,
    output logic             r01,
    output logic             r10,
    output logic             r11,
    output logic             sel,
    input  logic             sc_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int IDXW = WIDTH + 1;
    localparam int LEN  = (1 << WIDTH) - 1;
    localparam logic [IDXW-1:0] LEN_I  = IDXW'(LEN);
    localparam logic [IDXW-1:0] PIPE_I = IDXW'(PIPE_DLY);
    localparam logic [IDXW-1:0] LAST_I = IDXW'(LEN + PIPE_DLY - 1);
`ifdef SC_SHARED_RNG_EN
    localparam int NPIX = 1;
`else
    localparam int NPIX = 4;
`endif
    // Pixel generators occupy 0..NPIX-1; the select generator is always last.
    localparam int NUM_RNG = NPIX + 1;
    localparam int SEL_RNG = NPIX;

    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    localparam logic [15:0]      TAP16 = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0] TAPS  = TAP16[WIDTH-1:0];

    function automatic logic [WIDTH-1:0] seed_of(input int i);
        if (i == SEL_RNG) return WIDTH'(5);
        case (i)
            0:       return WIDTH'(1);
            1:       return {WIDTH{1'b1}};
            2:       return WIDTH'(LEN >> 1);
            default: return WIDTH'(LEN - 3);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                          state_q, state_d;
    logic [IDXW-1:0]                 idx_q, idx_d;
    logic [WIDTH-1:0]                result_q, result_d;
    logic [3:0][WIDTH-1:0]           pix_q, pix_d;
    logic [NUM_RNG-1:0][WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [3:0]                      r_q, r_d, cmp;
    logic                            sel_q, sel_d;
    logic                            emit_next;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        pix_d    = pix_q;
        lfsr_d   = lfsr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    pix_d    = {p11, p10, p01, p00};
                    result_d = '0;
                    idx_d    = '0;
                    state_d  = RUN;
                    for (int i = 0; i < NUM_RNG; i++) lfsr_d[i] = seed_of(i);
                end
            end
            RUN: begin
                for (int i = 0; i < NUM_RNG; i++) lfsr_d[i] = lfsr_step(lfsr_q[i]);
                // The first PIPE_DLY returned bits predate this frame's streams.
                if (sc_out && (idx_q >= PIPE_I)) result_d = result_q + WIDTH'(1);
                if (idx_q == LAST_I) state_d = DONE;
                else                 idx_d   = idx_q + IDXW'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Streams are registered against the LFSR state that will be current next cycle.
    assign emit_next = (state_d == RUN) && (idx_d < LEN_I);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cmp
            localparam int RI = (NPIX == 1) ? 0 : gi;
            assign cmp[gi] = (pix_d[gi] >= lfsr_d[RI]);
        end
    endgenerate

    assign r_d   = emit_next ? cmp : 4'b0000;
    assign sel_d = emit_next & lfsr_d[SEL_RNG][WIDTH-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            result_q <= '0;
            pix_q    <= '0;
            r_q      <= '0;
            sel_q    <= 1'b0;
            for (int i = 0; i < NUM_RNG; i++) lfsr_q[i] <= seed_of(i);
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            pix_q    <= pix_d;
            lfsr_q   <= lfsr_d;
            r_q      <= r_d;
            sel_q    <= sel_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign r00       = r_q[0];
    assign r01       = r_q[1];
    assign r10       = r_q[2];
    assign r11       = r_q[3];
    assign sel       = sel_q;
endmodule

// File: tb/tb_sc_robert_stream_io.sv
// Loopback bench: r00 (or r00^r11) is fed back to sc_out through PIPE_DLY registers; results go through a scoreboard queue.
module tb_sc_robert_stream_io;
    localparam int WIDTH    = 8;
    localparam int PIPE_DLY = 2;
    localparam int LEN      = (1 << WIDTH) - 1;

    logic clk = 1'b0;
    logic reset, in_valid, in_ready, out_valid, out_ready, busy, sc_out;
    logic r00, r01, r10, r11, sel;
    logic [WIDTH-1:0] p00, p01, p10, p11, result;
    logic mode_xor;
    logic [PIPE_DLY-1:0] dly;

    always #5 clk = ~clk;

    sc_robert_stream_io #(.WIDTH(WIDTH), .PIPE_DLY(PIPE_DLY)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11),
        .r00(r00), .r01(r01), .r10(r10), .r11(r11), .sel(sel),
        .sc_out(sc_out), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always @(posedge clk) dly <= {dly[PIPE_DLY-2:0], (mode_xor ? (r00 ^ r11) : r00)};
    assign sc_out = dly[PIPE_DLY-1];

    // kind 0: exact result; kind 1: result must be nonzero
    typedef struct {
        logic [WIDTH-1:0] a, b, c, d;
        logic             xr;
        int               kind;
        int               exp;
        int               hold;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        int exp;
        logic [WIDTH-1:0] held;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_idle", int'(in_ready), 1);
        mode_xor = v.xr;
        p00 = v.a; p01 = v.b; p10 = v.c; p11 = v.d;
        in_valid = 1'b1;
        exp_q.push_back(v.exp);
        @(negedge clk);
        in_valid = 1'b0;
        p00 = '1; p01 = '1; p10 = '1; p11 = '1;
        chk("busy_run", int'(busy), 1);
        chk("in_ready_run", int'(in_ready), 0);
        n = 1;
        while (!out_valid && n < 600) begin @(negedge clk); n++; end
        chk("run_cycles", n - 1, LEN + PIPE_DLY);
        chk("streams_done", int'({r00, r01, r10, r11, sel}), 0);
        held = result;
        for (int k = 0; k < v.hold; k++) begin
            in_valid = 1'b1;
            p00 = 8'h5A;
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_result", int'(result), int'(held));
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            exp = exp_q.pop_front();
            if (v.kind == 0) chk("result", int'(result), exp);
            else             chk("result_nonzero", int'(result != 0), 1);
        end
        $display("frame p00=%0d p11=%0d xor=%0d hold=%0d result=%0d", v.a, v.d, v.xr, v.hold, result);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode_xor = 1'b0;
        p00 = '0; p01 = '0; p10 = '0; p11 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_streams", int'({r00, r01, r10, r11, sel}), 0);

        vecs[0] = '{a: 8'd0,   b: 8'd9,   c: 8'd200, d: 8'd17,  xr: 1'b0, kind: 0, exp: 0,   hold: 0};
        vecs[1] = '{a: 8'd255, b: 8'd0,   c: 8'd3,   d: 8'd255, xr: 1'b0, kind: 0, exp: 255, hold: 0};
        vecs[2] = '{a: 8'd100, b: 8'd50,  c: 8'd150, d: 8'd250, xr: 1'b0, kind: 0, exp: 100, hold: 10};
        vecs[3] = '{a: 8'd1,   b: 8'd1,   c: 8'd1,   d: 8'd1,   xr: 1'b0, kind: 0, exp: 1,   hold: 1};
        vecs[4] = '{a: 8'd254, b: 8'd77,  c: 8'd0,   d: 8'd99,  xr: 1'b0, kind: 0, exp: 254, hold: 0};
`ifdef SC_SHARED_RNG_EN
        vecs[5] = '{a: 8'd128, b: 8'd40,  c: 8'd80,  d: 8'd128, xr: 1'b1, kind: 0, exp: 0,   hold: 0};
`else
        vecs[5] = '{a: 8'd128, b: 8'd40,  c: 8'd80,  d: 8'd128, xr: 1'b1, kind: 1, exp: 1,   hold: 0};
`endif
        vecs[6] = '{a: 8'd37,  b: 8'd200, c: 8'd13,  d: 8'd66,  xr: 1'b0, kind: 0, exp: 37,  hold: 2};

        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // Reset in the middle of a frame at idx 50.
        @(negedge clk);
        mode_xor = 1'b0;
        p00 = 8'd200; in_valid = 1'b1;
        exp_q.push_back(200);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (50) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_streams", int'({r00, r01, r10, r11, sel}), 0);
        void'(exp_q.pop_front());
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int k = 0; k < 300; k++) begin
                @(negedge clk);
                if (out_valid) seen++;
            end
            chk("no_valid_after_rst", seen, 0);
        end
        $display("reset at idx 50: busy=%0d result=%0d", busy, result);
        run_frame('{a: 8'd77, b: 8'd1, c: 8'd2, d: 8'd3, xr: 1'b0, kind: 0, exp: 77, hold: 0});

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sc_robert_stream_io.md
SC_ROBERT_STREAM_IO -- requirements
Module: sc_robert_stream_io

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel, LFSR and result width (legal 4..16).
REQ-002 SHALL have parameter PIPE_DLY, default 2: cycles from stream-bit emission to the matching sc_out bit (legal 0..7).
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  pixel quad offered; in_ready  output  1  quad accepted when both high.
REQ-006 p00, p01, p10, p11  input  WIDTH each  unsigned 2x2 pixel window.
REQ-007 r00, r01, r10, r11  output  1 each  registered stochastic pixel streams.
REQ-008 sel  output  1  registered select stream, probability near 0.5.
REQ-009 sc_out  input  1  returned stochastic result bit from the edge-detect datapath.
REQ-010 out_valid  output  1; out_ready  input  1; result  output  WIDTH  count of ones on sc_out.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE; LEN = 2^WIDTH - 1.
REQ-013 IDLE: in_ready=1; on in_valid, capture p00..p11, reload all LFSR seeds, clear result and cycle counter, enter RUN.
REQ-014 RUN SHALL last exactly LEN+PIPE_DLY cycles, counter idx 0..LEN+PIPE_DLY-1; in_ready=0.
REQ-015 For idx < LEN, each rXY SHALL equal (pXY >= lfsr) at its LFSR state; for idx >= LEN all streams SHALL be 0.
REQ-016 LFSRs SHALL be maximal-length WIDTH-bit Fibonacci, nonzero seeds, stepping once per RUN cycle; a full period gives exactly pXY ones.
REQ-017 sel SHALL be the MSB of a dedicated LFSR never shared with pixel streams.
REQ-018 result SHALL increment when sc_out=1 and idx >= PIPE_DLY; WIDTH bits, no wrap (max LEN fits).
REQ-019 After final RUN cycle, enter DONE: out_valid=1, result held stable until out_ready=1.
REQ-020 DONE with out_ready=1: out_valid drops next cycle, enter IDLE; a new quad is accepted no earlier than the following cycle.
REQ-021 in_valid outside IDLE SHALL be ignored; pixel inputs sampled only at acceptance.
REQ-022 Streams and sel SHALL be 0 in IDLE and DONE.

Reset
REQ-023 reset SHALL asynchronously force IDLE, in_ready=1 after release, out_valid=0, busy=0, result=0, all streams and sel=0, LFSRs to seed.
REQ-024 reset mid-RUN or mid-DONE SHALL discard the frame; no out_valid produced.

Configuration
REQ-025 Macro SC_SHARED_RNG_EN defined: all four pixel streams compare against one shared LFSR (maximally correlated streams).
REQ-026 Macro SC_SHARED_RNG_EN undefined: each pixel stream has its own LFSR with distinct seed (mutually uncorrelated streams).

Verification
REQ-027 WIDTH=8, bench loops r00 to sc_out through PIPE_DLY registers, p00=0 -> result=0, out_valid after 257 RUN cycles.
REQ-028 Same loopback, p00=255 -> result=255; p00=100 -> result=100 exactly.
REQ-029 out_ready held low 10 cycles in DONE -> out_valid=1, result stable, in_ready=0, in_valid ignored.
REQ-030 reset asserted at idx=50 -> same-cycle outputs zero, busy=0; next quad completes normally.
REQ-031 SC_SHARED_RNG_EN defined, p00=p11=128, sc_out=r00 XOR r11 delayed -> result=0; undefined -> result nonzero.
